// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the RAM arbiter.
//   - arb_state_e     : arbiter state encoding (RUN / SCR / UART / RESTORE)
//   - RAM_ADDR_WIDTH  : default RAM address width
//   - RAM_DATA_WIDTH  : default RAM data width
package ram_arb_pkg;

    localparam int unsigned RAM_ADDR_WIDTH = 11;
    localparam int unsigned RAM_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,  // CPU owns the RAM
        ST_SCR     = 2'd1,  // screen reader owns the RAM
        ST_UART    = 2'd2,  // program loader owns the RAM
        ST_RESTORE = 2'd3   // CPU address re-read before RDY returns
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of every master-side and RAM-side signal of the arbiter.
//   CPU    : cpu_addr, cpu_wdata, cpu_we, cpu_sync -> ; <- cpu_rdy
//   Screen : scr_req, scr_addr -> ; <- scr_grant, scr_rdata_valid
//   Loader : uart_req, uart_addr, uart_wdata, uart_we -> ; <- uart_grant
//   RAM    : <- ram_raddr, ram_waddr, ram_wdata, ram_we
// Modports: master (the surrounding system / bench), slave (the arbiter).
interface ram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [15:0]           cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_we;
    logic                  cpu_sync;
    logic                  cpu_rdy;

    logic                  scr_req;
    logic [ADDR_WIDTH-1:0] scr_addr;
    logic                  scr_grant;
    logic                  scr_rdata_valid;

    logic                  uart_req;
    logic [ADDR_WIDTH-1:0] uart_addr;
    logic [DATA_WIDTH-1:0] uart_wdata;
    logic                  uart_we;
    logic                  uart_grant;

    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_sync,
        output scr_req, scr_addr,
        output uart_req, uart_addr, uart_wdata, uart_we,
        input  cpu_rdy, scr_grant, scr_rdata_valid, uart_grant,
        input  ram_raddr, ram_waddr, ram_wdata, ram_we
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_sync,
        input  scr_req, scr_addr,
        input  uart_req, uart_addr, uart_wdata, uart_we,
        output cpu_rdy, scr_grant, scr_rdata_valid, uart_grant,
        output ram_raddr, ram_waddr, ram_wdata, ram_we
    );

endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous-read RAM between the 6502 core, the VGA
// screen reader and the UART program loader.
//   clk      : system clock
//   reset_n  : synchronous reset, active low
//   io_bus   : ram_arbiter_if.slave carrying all master and RAM signals
// The CPU is only paused at an instruction boundary (cpu_sync). Every grant is
// followed by one RESTORE cycle so the CPU's held address is re-read before
// cpu_rdy rises again. Status outputs are registered; the RAM mux is
// combinational from the registered state only (never from a request).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.slave  io_bus
);

    arb_state_e            r_state;
    arb_state_e            w_state_next;
    logic                  r_cpu_rdy;
    logic                  r_scr_grant;
    logic                  r_uart_grant;
    logic                  r_scr_rdata_valid;

    logic [ADDR_WIDTH-1:0] w_cpu_addr;
    logic                  w_unused_cpu_addr;

    // Only the low address bits reach the RAM.
    assign w_cpu_addr        = io_bus.cpu_addr[ADDR_WIDTH-1:0];
    assign w_unused_cpu_addr = ^io_bus.cpu_addr[15:ADDR_WIDTH];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                // Screen wins when both request on the same sync.
                if ((io_bus.scr_req || io_bus.uart_req) && io_bus.cpu_sync) begin
                    w_state_next = io_bus.scr_req ? ST_SCR : ST_UART;
                end
            end
            ST_SCR: begin
                if (!io_bus.scr_req) begin
                    w_state_next = io_bus.uart_req ? ST_UART : ST_RESTORE;
                end
            end
            ST_UART: begin
                if (!io_bus.uart_req) begin
                    w_state_next = io_bus.scr_req ? ST_SCR : ST_RESTORE;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Outputs are registered from the next state so each one is exactly
    // aligned with the state it describes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state           <= ST_RESTORE;
            r_cpu_rdy         <= 1'b0;
            r_scr_grant       <= 1'b0;
            r_uart_grant      <= 1'b0;
            r_scr_rdata_valid <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_cpu_rdy         <= (w_state_next == ST_RUN);
            r_scr_grant       <= (w_state_next == ST_SCR);
            r_uart_grant      <= (w_state_next == ST_UART);
            // RAM has one cycle of read latency.
            r_scr_rdata_valid <= r_scr_grant;
        end
    end

    always_comb begin
        io_bus.ram_raddr = w_cpu_addr;
        io_bus.ram_waddr = w_cpu_addr;
        io_bus.ram_wdata = io_bus.cpu_wdata;
        io_bus.ram_we    = 1'b0;
        case (r_state)
            ST_RUN: begin
                io_bus.ram_we = io_bus.cpu_we;
            end
            ST_SCR: begin
                io_bus.ram_raddr = io_bus.scr_addr;
            end
            ST_UART: begin
                io_bus.ram_raddr = io_bus.uart_addr;
                io_bus.ram_waddr = io_bus.uart_addr;
                io_bus.ram_wdata = io_bus.uart_wdata;
                io_bus.ram_we    = io_bus.uart_we;
            end
            default: begin
                io_bus.ram_we = 1'b0;
            end
        endcase
        // Kill any write as soon as reset is asserted, even mid-grant.
        if (!reset_n) begin
            io_bus.ram_we = 1'b0;
        end
    end

    assign io_bus.cpu_rdy         = r_cpu_rdy;
    assign io_bus.scr_grant       = r_scr_grant;
    assign io_bus.uart_grant      = r_uart_grant;
    assign io_bus.scr_rdata_valid = r_scr_rdata_valid;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter. Expected values are queued
// as stimulus is applied and popped in order when the outputs are sampled.
module tb_ram_arbiter;

    logic clk;
    logic reset_n;

    ram_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();

    ram_arbiter #(
        .ADDR_WIDTH(11),
        .DATA_WIDTH(8)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push_exp(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty: got %0h required nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: got %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Inputs change 1 time unit after the edge, samples are taken 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        bus.cpu_addr   = 16'h0000;
        bus.cpu_wdata  = 8'h00;
        bus.cpu_we     = 1'b1;
        bus.cpu_sync   = 1'b0;
        bus.scr_req    = 1'b0;
        bus.scr_addr   = '0;
        bus.uart_req   = 1'b0;
        bus.uart_addr  = '0;
        bus.uart_wdata = 8'h00;
        bus.uart_we    = 1'b0;

        // Reset held three cycles, writes must stay blocked.
        for (int i = 0; i < 3; i++) begin
            tick();
            push_exp($sformatf("rst_rdy%0d", i), 16'd0);
            push_exp($sformatf("rst_we%0d", i), 16'd0);
            push_exp($sformatf("rst_gnt%0d", i), 16'd0);
            pop_chk({15'd0, bus.cpu_rdy});
            pop_chk({15'd0, bus.ram_we});
            pop_chk({14'd0, bus.scr_grant, bus.uart_grant});
        end

        // First cycle after release is RESTORE: not ready, no write.
        reset_n = 1'b1;
        settle();
        push_exp("restore_rdy", 16'd0);
        push_exp("restore_we", 16'd0);
        pop_chk({15'd0, bus.cpu_rdy});
        pop_chk({15'd0, bus.ram_we});

        tick();
        push_exp("run_rdy", 16'd1);
        push_exp("run_gnt", 16'd0);
        pop_chk({15'd0, bus.cpu_rdy});
        pop_chk({14'd0, bus.scr_grant, bus.uart_grant});

        // CPU write passes straight through with the address truncated.
        bus.cpu_addr  = 16'hF205;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_we    = 1'b1;
        settle();
        push_exp("cpu_waddr", 16'h0205);
        push_exp("cpu_raddr", 16'h0205);
        push_exp("cpu_we", 16'd1);
        push_exp("cpu_wdata", 16'h00A5);
        pop_chk({5'd0, bus.ram_waddr});
        pop_chk({5'd0, bus.ram_raddr});
        pop_chk({15'd0, bus.ram_we});
        pop_chk({8'd0, bus.ram_wdata});
        bus.cpu_we = 1'b0;

        // Screen request waits three cycles for sync.
        bus.cpu_addr = 16'h1234;
        bus.scr_req  = 1'b1;
        bus.scr_addr = 11'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            push_exp($sformatf("nosync_gnt%0d", i), 16'd0);
            push_exp($sformatf("nosync_rdy%0d", i), 16'd1);
            pop_chk({15'd0, bus.scr_grant});
            pop_chk({15'd0, bus.cpu_rdy});
        end
        bus.cpu_sync = 1'b1;
        settle();
        push_exp("sync_cycle_gnt", 16'd0);
        pop_chk({15'd0, bus.scr_grant});

        tick();
        bus.cpu_sync = 1'b0;
        bus.cpu_we   = 1'b1;
        settle();
        push_exp("scr_gnt", 16'd1);
        push_exp("scr_rdy", 16'd0);
        push_exp("scr_raddr", 16'h0200);
        push_exp("scr_we", 16'd0);
        push_exp("scr_valid0", 16'd0);
        pop_chk({15'd0, bus.scr_grant});
        pop_chk({15'd0, bus.cpu_rdy});
        pop_chk({5'd0, bus.ram_raddr});
        pop_chk({15'd0, bus.ram_we});
        pop_chk({15'd0, bus.scr_rdata_valid});
        bus.cpu_we = 1'b0;

        tick();
        push_exp("scr_valid1", 16'd1);
        pop_chk({15'd0, bus.scr_rdata_valid});

        bus.scr_req = 1'b0;
        tick();
        push_exp("scr_rel_gnt", 16'd0);
        push_exp("scr_rel_valid", 16'd1);
        push_exp("scr_rel_rdy", 16'd0);
        push_exp("scr_rel_raddr", 16'h0234);
        pop_chk({15'd0, bus.scr_grant});
        pop_chk({15'd0, bus.scr_rdata_valid});
        pop_chk({15'd0, bus.cpu_rdy});
        pop_chk({5'd0, bus.ram_raddr});

        tick();
        push_exp("scr_back_rdy", 16'd1);
        push_exp("scr_back_valid", 16'd0);
        pop_chk({15'd0, bus.cpu_rdy});
        pop_chk({15'd0, bus.scr_rdata_valid});

        // Both request on one sync: screen first, loader straight after.
        bus.scr_req  = 1'b1;
        bus.uart_req = 1'b1;
        bus.cpu_sync = 1'b1;
        tick();
        bus.cpu_sync = 1'b0;
        push_exp("both_scr_first", 16'b10);
        pop_chk({14'd0, bus.scr_grant, bus.uart_grant});
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        push_exp("both_scr_held", 16'b10);
        pop_chk({14'd0, bus.scr_grant, bus.uart_grant});
        bus.scr_req = 1'b0;
        tick();
        bus.uart_we    = 1'b1;
        bus.uart_addr  = 11'h600;
        bus.uart_wdata = 8'hEA;
        settle();
        push_exp("uart_gnt", 16'b01);
        push_exp("uart_rdy", 16'd0);
        push_exp("uart_we", 16'd1);
        push_exp("uart_waddr", 16'h0600);
        push_exp("uart_raddr", 16'h0600);
        push_exp("uart_wdata", 16'h00EA);
        pop_chk({14'd0, bus.scr_grant, bus.uart_grant});
        pop_chk({15'd0, bus.cpu_rdy});
        pop_chk({15'd0, bus.ram_we});
        pop_chk({5'd0, bus.ram_waddr});
        pop_chk({5'd0, bus.ram_raddr});
        pop_chk({8'd0, bus.ram_wdata});

        bus.uart_we  = 1'b0;
        bus.uart_req = 1'b0;
        bus.cpu_addr = 16'hABCD;
        tick();
        push_exp("uart_rel_gnt", 16'd0);
        push_exp("uart_rel_rdy", 16'd0);
        push_exp("uart_rel_raddr", 16'h03CD);
        pop_chk({14'd0, bus.scr_grant, bus.uart_grant});
        pop_chk({15'd0, bus.cpu_rdy});
        pop_chk({5'd0, bus.ram_raddr});
        tick();
        push_exp("uart_back_rdy", 16'd1);
        pop_chk({15'd0, bus.cpu_rdy});

        // Reset while the loader is writing.
        bus.uart_req = 1'b1;
        bus.cpu_sync = 1'b1;
        tick();
        bus.cpu_sync   = 1'b0;
        bus.uart_we    = 1'b1;
        bus.uart_addr  = 11'h155;
        bus.uart_wdata = 8'h3C;
        settle();
        push_exp("mid_gnt", 16'd1);
        push_exp("mid_we_pre", 16'd1);
        pop_chk({15'd0, bus.uart_grant});
        pop_chk({15'd0, bus.ram_we});
        reset_n = 1'b0;
        settle();
        push_exp("mid_we_rst", 16'd0);
        pop_chk({15'd0, bus.ram_we});
        tick();
        push_exp("mid_gnt_drop", 16'd0);
        push_exp("mid_we_hold", 16'd0);
        pop_chk({15'd0, bus.uart_grant});
        pop_chk({15'd0, bus.ram_we});
        reset_n      = 1'b1;
        bus.uart_req = 1'b0;
        bus.uart_we  = 1'b0;
        settle();
        push_exp("mid_restore_rdy", 16'd0);
        pop_chk({15'd0, bus.cpu_rdy});
        tick();
        push_exp("mid_run_rdy", 16'd1);
        pop_chk({15'd0, bus.cpu_rdy});

        // Fairness: screen re-requests immediately, sync held high.
        bus.scr_req  = 1'b1;
        bus.cpu_sync = 1'b1;
        tick();
        push_exp("fair_gnt0", 16'd1);
        pop_chk({15'd0, bus.scr_grant});
        bus.scr_req = 1'b0;
        tick();
        bus.scr_req = 1'b1;
        push_exp("fair_restore", 16'b00);
        pop_chk({bus.scr_grant, 14'd0, bus.cpu_rdy});
        tick();
        push_exp("fair_run", 16'b01);
        pop_chk({bus.scr_grant, 14'd0, bus.cpu_rdy});
        tick();
        push_exp("fair_gnt1", 16'd1);
        pop_chk({15'd0, bus.scr_grant});

        // Second release, sync arrives late: grant waits for it.
        bus.scr_req  = 1'b0;
        bus.cpu_sync = 1'b0;
        tick();
        bus.scr_req = 1'b1;
        push_exp("late_restore", 16'b00);
        pop_chk({bus.scr_grant, 14'd0, bus.cpu_rdy});
        tick();
        push_exp("late_run0", 16'b01);
        pop_chk({bus.scr_grant, 14'd0, bus.cpu_rdy});
        tick();
        push_exp("late_run1", 16'b01);
        pop_chk({bus.scr_grant, 14'd0, bus.cpu_rdy});
        bus.cpu_sync = 1'b1;
        tick();
        bus.cpu_sync = 1'b0;
        push_exp("late_gnt", 16'd1);
        pop_chk({15'd0, bus.scr_grant});

        bus.scr_req = 1'b0;
        tick();

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover: got %0d required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
